// File: rtl/multiplier_4b.sv
// -----------------------------------------------------------------------------
// multiplier_4b
//   Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
//   One iteration per clock. The product is available 4 clocks after start is
//   accepted (for WIDTH=4). The result is held until the next completion.
//
//   Optional build macro: MULTIPLIER_4B_SIGNED_EN
//     undefined : unsigned operands and product (default)
//     defined   : two's complement operands and product. The multiplicand is
//                 sign-extended, and the multiplier MSB partial product is
//                 subtracted. Ports and timing do not change.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   request a multiplication (ignored while busy)
//   a      in   multiplicand, captured on the accept edge
//   b      in   multiplier, captured on the accept edge
//   result out  registered product, held between operations
//   busy   out  high while an operation is in flight
//   done   out  one-cycle pulse when result is new
// -----------------------------------------------------------------------------
module multiplier_4b #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]  mplier_q, mplier_d; // multiplier, shifted right each iteration
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     result_q, result_d;
  logic              done_q, done_d;

  // Partial-product step for the current iteration.
  logic              last_iter;
  logic [PW-1:0]     acc_step;

  assign last_iter = (cnt_q == LAST_ITER);

  always_comb begin
    acc_step = acc_q;
    if (mplier_q[0]) begin
`ifdef MULTIPLIER_4B_SIGNED_EN
      // The multiplier MSB carries weight -2^(WIDTH-1), so its partial
      // product is subtracted. Modulo-2^PW arithmetic makes the result exact.
      acc_step = last_iter ? (acc_q - mcand_q) : (acc_q + mcand_q);
`else
      acc_step = acc_q + mcand_q;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every signal gets a default first, so that no path through the
    // block leaves a value unassigned and no latch is inferred.
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MULTIPLIER_4B_SIGNED_EN
          mcand_d = {{WIDTH{a[WIDTH-1]}}, a};
`else
          mcand_d = {{WIDTH{1'b0}}, a};
`endif
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          result_d = acc_step;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state here is a handful of flops, not a memory, so every
  // register is reset. Reset aborts an in-flight operation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q == BUSY);

endmodule

// File: tb/tb_multiplier_4b.sv
// -----------------------------------------------------------------------------
// tb_multiplier_4b
//   Directed bench for multiplier_4b: reset, products, hold, handshake,
//   back-to-back operation and reset abort. Expected values are hand-computed
//   for the unsigned build, or for the signed build when
//   MULTIPLIER_4B_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_multiplier_4b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [7:0] result;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

`ifdef MULTIPLIER_4B_SIGNED_EN
  localparam logic [7:0] EXP_10_6  = 8'hDC; // -6 * 6   = -36
  localparam logic [7:0] EXP_15_15 = 8'h01; // -1 * -1  = 1
  localparam logic [7:0] EXP_13_5  = 8'hF1; // -3 * 5   = -15
  localparam logic [7:0] EXP_8_8   = 8'h40; // -8 * -8  = 64
  localparam logic [7:0] EXP_8_7   = 8'hC8; // -8 * 7   = -56
`else
  localparam logic [7:0] EXP_10_6  = 8'h3C; // 60
  localparam logic [7:0] EXP_15_15 = 8'hE1; // 225
  localparam logic [7:0] EXP_13_5  = 8'h41; // 65
  localparam logic [7:0] EXP_8_8   = 8'h40; // 64
  localparam logic [7:0] EXP_8_7   = 8'h38; // 56
`endif

  always #5 clk = ~clk;

  multiplier_4b dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation with a single-cycle start pulse. When disturb is set,
  // start is pulsed again while busy, and a/b are changed after the accept.
  task automatic run_op(input string tag, input logic [3:0] op_a, input logic [3:0] op_b,
                        input logic [7:0] exp, input bit disturb);
    @(negedge clk);
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(posedge clk); #1;                 // accept edge k
    start = 1'b0;
    check({tag, "_busy_k"}, {7'd0, busy}, 8'd1);
    check({tag, "_done_k"}, {7'd0, done}, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (disturb && i == 1) begin
        start = 1'b1;
        a = 4'd1;
        b = 4'd1;
      end
      if (disturb && i == 2) begin
        start = 1'b0;
        a = 4'hA;
        b = 4'h3;
      end
      if (i < 4) begin
        check({tag, "_busy_mid"}, {7'd0, busy}, 8'd1);
        check({tag, "_done_mid"}, {7'd0, done}, 8'd0);
      end
    end
    check({tag, "_done"},   {7'd0, done}, 8'd1);
    check({tag, "_busy"},   {7'd0, busy}, 8'd0);
    check({tag, "_result"}, result, exp);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, {7'd0, done}, 8'd0);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    // Reset state while rst is held.
    #2;
    check("rst_result", result, 8'h00);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic product, then hold with changed operands and no start.
    run_op("mul_3x5", 4'd3, 4'd5, 8'h0F, 1'b0);
    @(negedge clk);
    a = 4'd7;
    b = 4'd7;
    repeat (10) @(posedge clk);
    #1;
    check("hold_result", result, 8'h0F);
    check("hold_done", {7'd0, done}, 8'd0);
    check("hold_busy", {7'd0, busy}, 8'd0);

    run_op("mul_10x6", 4'd10, 4'd6, EXP_10_6, 1'b0);
    run_op("mul_5x6", 4'd5, 4'd6, 8'h1E, 1'b0);
    run_op("mul_0x9", 4'd0, 4'd9, 8'h00, 1'b0);
    run_op("mul_15x15", 4'd15, 4'd15, EXP_15_15, 1'b0);
    run_op("mul_13x5", 4'd13, 4'd5, EXP_13_5, 1'b0);
    run_op("mul_8x8", 4'd8, 4'd8, EXP_8_8, 1'b0);
    run_op("mul_8x7", 4'd8, 4'd7, EXP_8_7, 1'b0);

    // Start while busy is ignored; operand changes after accept have no effect.
    run_op("ignore_2x7", 4'd2, 4'd7, 8'h0E, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("ignore_no_extra_done", {7'd0, done}, 8'd0);
    check("ignore_idle", {7'd0, busy}, 8'd0);
    check("ignore_result", result, 8'h0E);

    // Reset while idle clears a nonzero result immediately.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_idle_result", result, 8'h00);
    check("rst_idle_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start held high: accepted every 5 cycles, done on every fifth edge.
    @(negedge clk);
    a = 4'd3;
    b = 4'd4;
    start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check("held_done", {7'd0, done}, {7'd0, (i % 5 == 4)});
      check("held_busy", {7'd0, busy}, {7'd0, (i % 5 != 4)});
      if (i % 5 == 4) check("held_result", result, 8'h0C);
    end
    start = 1'b0;

    // Reset two cycles into an operation aborts it with no later done.
    @(negedge clk);
    a = 4'd3;
    b = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy_before", {7'd0, busy}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_result", result, 8'h00);
    check("abort_done", {7'd0, done}, 8'd0);
    check("abort_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", {7'd0, done}, 8'd0);
      check("abort_stays_idle", {7'd0, busy}, 8'd0);
    end
    check("abort_result_after", result, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_4b.md
Name: multiplier_4b

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier producing an 8-bit product.
- Small arithmetic leaf block for datapaths that can tolerate a few cycles of latency in exchange for minimal area.
- Uses a start/done handshake. The result is held stable until the next operation completes.

Parameters:
- WIDTH, 4, operand width. The product is 2*WIDTH bits. The block is verified only at 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a multiplication; sampled on clk rising edge
- a  input  4  multiplicand; captured when start is accepted
- b  input  4  multiplier; captured when start is accepted
- result  output  8  product a*b; registered
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result is valid and new

Interface: one clock; reset is asynchronous and active-high (clk, rst).

Behaviour:
- Reset (asynchronous assert; deassert is synchronised externally): state=IDLE, result=0, done=0, busy=0, internal operand/accumulator registers=0.
- States: IDLE, BUSY.
- IDLE -> BUSY: on a clk edge with start=1.
  - At that edge (call it k): latch a and b, clear the accumulator, set the iteration count to 0.
- BUSY: one iteration per edge, at edges k+1 through k+4.
  - If the current multiplier LSB is 1, add the left-shifted multiplicand into the 8-bit accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
- Completion at edge k+4:
  - result <= final accumulator.
  - done <= 1.
  - state -> IDLE.
- done falls at edge k+5 unless another operation completes at that edge.
- Latency: 4 clocks from the start-accept edge to done/result visible.
- busy is decoded from the state: 1 in BUSY, 0 in IDLE. It is high from after edge k until after edge k+4.
- start while BUSY is ignored. It is not queued and operands are not re-sampled.
- start during the cycle done is high is accepted, because the state is already IDLE. This gives back-to-back throughput of 1 result per 5 cycles.
- Changes on a/b after the accept edge do not affect the in-flight operation.
- result holds its last value between operations. It changes only at a completion edge or on reset.
- Reset mid-operation aborts immediately: state=IDLE, result=0, done=0.
- Width and overflow:
  - The accumulator is 8 bits. The maximum unsigned product is 15*15=225 (0xE1), so overflow cannot occur.
  - There is no saturation or carry-out port.
- Zero operands follow the same 4-cycle path. There is no early termination.

Optional Feature:
- Macro MULTIPLIER_4B_SIGNED_EN.
- Defined: a, b and result are two's complement. Implemented with a Baugh-Wooley (or equivalent sign-extended) partial-product scheme within the same 4-iteration latency.
  - Example: -3*5 = -15 = 0xF1; -8*-8 = 64 = 0x40; -8*7 = -56 = 0xC8.
- Not defined: unsigned operation as described above.
- Port list and timing are identical in both builds.

Test Plan:
- Reset: assert rst mid-idle, then mid-BUSY (2 cycles after start) -> result=0x00, done=0, busy=0 immediately; no done pulse afterwards.
- Basic products, each started with a one-cycle start pulse:
  - a=3, b=5 -> done 4 clocks later, result=15 (0x0F).
  - a=10, b=6 -> result=60 (0x3C).
  - a=5, b=6 -> result=30 (0x1E).
- Zero/extreme operands:
  - a=0, b=9 -> result=0 after the full 4-cycle latency.
  - a=15, b=15 -> result=225 (0xE1).
- Handshake and back-to-back:
  - start held high continuously -> accepts every 5 cycles.
  - start pulsed again while busy=1 with a=1, b=1 -> ignored; the in-flight result is unchanged.
  - a/b toggled after accept -> no effect on the in-flight result.
- Hold: after done for 3*5, drive a=7, b=7 without start -> result remains 15 indefinitely.
- Signed build (MULTIPLIER_4B_SIGNED_EN): a=-3 (0xD), b=5 -> 0xF1; a=-8, b=-8 -> 0x40; a=-1, b=-1 -> 0x01.
